// File: rtl/sram_axi_bridge_if.sv
// Bus bundles for the SRAM-like core ports and the single-beat AXI3 master port.
// The core drives sram_if.master; the bridge presents sram_if.slave and axi_if.master.

interface sram_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (output req, wr, size, wstrb, addr, wdata,
                  input  addr_ok, data_ok, rdata);
  modport slave  (input  req, wr, size, wstrb, addr, wdata,
                  output addr_ok, data_ok, rdata);
endinterface

interface axi_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
                  input  arready,
                  input  rid, rdata, rresp, rlast, rvalid,
                  output rready,
                  output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
                  input  awready,
                  output wid, wdata, wstrb, wlast, wvalid,
                  input  wready,
                  input  bid, bresp, bvalid,
                  output bready);
  modport slave  (input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
                  output arready,
                  output rid, rdata, rresp, rlast, rvalid,
                  input  rready,
                  input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
                  output awready,
                  output wid, wdata, wstrb, wlast, wvalid,
                  output wready,
                  output bid, bresp, bvalid,
                  input  bready);
endinterface

// File: rtl/sram_axi_bridge.sv
// Merges the core's inst/data SRAM-like ports onto one AXI3 master with single-beat bursts.
// One read FSM (inst/data arbitrated, data first) and one write FSM (data port only).
//
// Handshakes: every AXI channel is valid/ready; a beat transfers on the rising edge where
// both are high, and valid plus its payload stay unchanged until that edge. On the SRAM side
// addr_ok marks acceptance of req in the same cycle; data_ok is a one-cycle response pulse.

module sram_axi_bridge (
  input  logic        clk,
  input  logic        reset,
  sram_if.slave       inst_sram,
  sram_if.slave       data_sram,
  axi_if.master       axi,
  output logic [1:0]  dbg_r_state,
  output logic [1:0]  dbg_w_state
);

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_AR = 2'd1, R_R = 2'd2} r_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_AW = 2'd1, W_B = 2'd2} w_state_t;

  r_state_t    r_state;
  w_state_t    w_state;
  logic [3:0]  ar_id;
  logic [31:0] ar_addr;
  logic [2:0]  ar_size;
  logic        arvalid_q;
  logic        rready_q;
  logic [31:0] aw_addr;
  logic [2:0]  aw_size;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        awvalid_q;
  logic        wvalid_q;
  logic        bready_q;

  logic r_idle, w_idle;
  logic data_rd_req, data_wr_req;
  logic rd_grant_data, rd_grant_inst, wr_grant;
  logic r_fire, b_fire, aw_left, w_left;

  assign r_idle      = (r_state == R_IDLE);
  assign w_idle      = (w_state == W_IDLE);
  assign data_rd_req = data_sram.req & ~data_sram.wr;
  assign data_wr_req = data_sram.req &  data_sram.wr;

  // A data read waits for the write side to drain; the inst port may slip in meanwhile.
  assign rd_grant_data = r_idle & w_idle & data_rd_req;
  assign rd_grant_inst = r_idle & inst_sram.req & ~rd_grant_data;
  assign wr_grant      = w_idle & data_wr_req & (r_idle | (ar_id == 4'd0));

  assign r_fire  = (r_state == R_R) & axi.rvalid;
  assign b_fire  = (w_state == W_B) & axi.bvalid;
  assign aw_left = awvalid_q & ~axi.awready;
  assign w_left  = wvalid_q  & ~axi.wready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= R_IDLE;
      ar_id     <= 4'd0;
      ar_addr   <= 32'd0;
      ar_size   <= 3'd0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: if (rd_grant_data || rd_grant_inst) begin
          ar_id     <= rd_grant_data ? 4'd1 : 4'd0;
          ar_addr   <= rd_grant_data ? data_sram.addr : inst_sram.addr;
          ar_size   <= {1'b0, (rd_grant_data ? data_sram.size : inst_sram.size)};
          arvalid_q <= 1'b1;
          r_state   <= R_AR;
        end
        R_AR: if (axi.arready) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          r_state   <= R_R;
        end
        R_R: if (axi.rvalid) begin
          rready_q <= 1'b0;
          r_state  <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state   <= W_IDLE;
      aw_addr   <= 32'd0;
      aw_size   <= 3'd0;
      w_data    <= 32'd0;
      w_strb    <= 4'd0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (wr_grant) begin
          aw_addr   <= data_sram.addr;
          aw_size   <= {1'b0, data_sram.size};
          w_data    <= data_sram.wdata;
          w_strb    <= data_sram.wstrb;
          awvalid_q <= 1'b1;
          wvalid_q  <= 1'b1;
          w_state   <= W_AW;
        end
        W_AW: begin
          // AW and W complete independently; move on once neither is still pending.
          awvalid_q <= aw_left;
          wvalid_q  <= w_left;
          if (!aw_left && !w_left) begin
            bready_q <= 1'b1;
            w_state  <= W_B;
          end
        end
        W_B: if (axi.bvalid) begin
          bready_q <= 1'b0;
          w_state  <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  assign axi.arid    = ar_id;
  assign axi.araddr  = ar_addr;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = ar_size;
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;
  assign axi.awid    = 4'd1;
  assign axi.awaddr  = aw_addr;
  assign axi.awlen   = 8'd0;
  assign axi.awsize  = aw_size;
  assign axi.awburst = 2'b01;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'd0;
  assign axi.awprot  = 3'd0;
  assign axi.awvalid = awvalid_q;
  assign axi.wid     = 4'd1;
  assign axi.wdata   = w_data;
  assign axi.wstrb   = w_strb;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;

  assign inst_sram.addr_ok = rd_grant_inst;
  assign data_sram.addr_ok = rd_grant_data | wr_grant;
  assign inst_sram.data_ok = r_fire & (axi.rid == 4'd0);
  assign data_sram.data_ok = (r_fire & (axi.rid == 4'd1)) | b_fire;
  assign inst_sram.rdata   = axi.rdata;
  assign data_sram.rdata   = axi.rdata;

  assign dbg_r_state = r_state;
  assign dbg_w_state = w_state;

  logic unused_inputs;
  assign unused_inputs = ^{inst_sram.wr, inst_sram.wstrb, inst_sram.wdata,
                           axi.rresp, axi.rlast, axi.bid, axi.bresp};

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: the bench plays core and AXI slave cycle by cycle.
// Inputs change 1ns after posedge; outputs are sampled 2ns after posedge.

module tb_sram_axi_bridge;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_r_state;
  logic [1:0] dbg_w_state;

  sram_if inst_sram();
  sram_if data_sram();
  axi_if  axi();

  sram_axi_bridge dut (
    .clk         (clk),
    .reset       (reset),
    .inst_sram   (inst_sram),
    .data_sram   (data_sram),
    .axi         (axi),
    .dbg_r_state (dbg_r_state),
    .dbg_w_state (dbg_w_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_sram.req = 0; inst_sram.wr = 0; inst_sram.size = 0; inst_sram.wstrb = 0;
    inst_sram.addr = 0; inst_sram.wdata = 0;
    data_sram.req = 0; data_sram.wr = 0; data_sram.size = 0; data_sram.wstrb = 0;
    data_sram.addr = 0; data_sram.wdata = 0;
    axi.arready = 1; axi.awready = 1; axi.wready = 1;
    axi.rid = 0; axi.rdata = 0; axi.rresp = 0; axi.rlast = 0; axi.rvalid = 0;
    axi.bid = 0; axi.bresp = 0; axi.bvalid = 0;
  endtask

  // driver: present one R beat this cycle
  task automatic drive_r(input logic [3:0] id, input logic [31:0] d);
    axi.rvalid = 1; axi.rid = id; axi.rdata = d; axi.rlast = 1;
  endtask

  task automatic pop_check(input string tag, input logic [31:0] got);
    if (exp_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s: got %h expected <empty queue>", tag, got);
    end else begin
      check_eq(tag, got, exp_q.pop_front());
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    repeat (3) tick();
    #1;
    check_eq("rst_arvalid", axi.arvalid, 0);
    check_eq("rst_rready", axi.rready, 0);
    check_eq("rst_aw_w_b", {axi.awvalid, axi.wvalid, axi.bready}, 0);
    check_eq("rst_araddr", axi.araddr, 0);
    check_eq("rst_dbg", {dbg_r_state, dbg_w_state}, 0);
    reset = 0;
    tick();

    // T1: ideal inst read
    inst_sram.req = 1; inst_sram.addr = 32'h1c000000; inst_sram.size = 2;
    exp_q.push_back(32'h02800c0c);
    #1;
    check_eq("t1_inst_addr_ok", inst_sram.addr_ok, 1);
    check_eq("t1_data_addr_ok", data_sram.addr_ok, 0);
    tick();
    inst_sram.req = 0; #1;
    check_eq("t1_arvalid", axi.arvalid, 1);
    check_eq("t1_araddr", axi.araddr, 32'h1c000000);
    check_eq("t1_arsize", axi.arsize, 2);
    check_eq("t1_arid", axi.arid, 0);
    check_eq("t1_arlen_burst", {axi.arlen, axi.arburst}, 10'b00000000_01);
    check_eq("t1_early_data_ok", inst_sram.data_ok, 0);
    tick();
    drive_r(4'd0, 32'h02800c0c); #1;
    check_eq("t1_rready", axi.rready, 1);
    check_eq("t1_inst_data_ok", inst_sram.data_ok, 1);
    pop_check("t1_inst_rdata", inst_sram.rdata);
    check_eq("t1_data_data_ok", data_sram.data_ok, 0);
    tick();
    axi.rvalid = 0; #1;
    check_eq("t1_after_data_ok", inst_sram.data_ok, 0);
    check_eq("t1_after_rready", axi.rready, 0);

    // T2: inst and data reads together, data wins
    inst_sram.req = 1; inst_sram.addr = 32'h1c000100; inst_sram.size = 2;
    data_sram.req = 1; data_sram.wr = 0; data_sram.addr = 32'h1c080040; data_sram.size = 2;
    #1;
    check_eq("t2_data_addr_ok", data_sram.addr_ok, 1);
    check_eq("t2_inst_addr_ok", inst_sram.addr_ok, 0);
    tick();
    data_sram.req = 0; #1;
    check_eq("t2_arid_data", axi.arid, 1);
    check_eq("t2_araddr_data", axi.araddr, 32'h1c080040);
    check_eq("t2_inst_wait_ar", inst_sram.addr_ok, 0);
    tick();
    drive_r(4'd1, 32'h11112222); #1;
    check_eq("t2_data_data_ok", data_sram.data_ok, 1);
    check_eq("t2_data_rdata", data_sram.rdata, 32'h11112222);
    check_eq("t2_inst_no_data_ok", inst_sram.data_ok, 0);
    check_eq("t2_inst_wait_r", inst_sram.addr_ok, 0);
    tick();
    axi.rvalid = 0; #1;
    check_eq("t2_inst_addr_ok", inst_sram.addr_ok, 1);
    tick();
    inst_sram.req = 0; #1;
    check_eq("t2_arid_inst", axi.arid, 0);
    check_eq("t2_araddr_inst", axi.araddr, 32'h1c000100);
    tick();
    drive_r(4'd0, 32'h33334444); #1;
    check_eq("t2_inst_data_ok", inst_sram.data_ok, 1);
    check_eq("t2_inst_rdata", inst_sram.rdata, 32'h33334444);
    check_eq("t2_data_no_data_ok", data_sram.data_ok, 0);
    tick();
    axi.rvalid = 0;

    // T3: data write, awready late, wready immediate
    axi.awready = 0;
    data_sram.req = 1; data_sram.wr = 1; data_sram.addr = 32'h1c0800f0;
    data_sram.wdata = 32'hdeadbeef; data_sram.wstrb = 4'b0011; data_sram.size = 1;
    #1;
    check_eq("t3_addr_ok", data_sram.addr_ok, 1);
    tick();
    data_sram.req = 0; data_sram.wr = 0; #1;
    check_eq("t3_aw_w_valid_c1", {axi.awvalid, axi.wvalid}, 2'b11);
    check_eq("t3_awaddr", axi.awaddr, 32'h1c0800f0);
    check_eq("t3_awsize", axi.awsize, 1);
    check_eq("t3_wdata", axi.wdata, 32'hdeadbeef);
    check_eq("t3_wstrb", axi.wstrb, 4'b0011);
    check_eq("t3_ids_last", {axi.awid, axi.wid, axi.wlast}, 9'b0001_0001_1);
    tick(); #1;
    check_eq("t3_aw_w_valid_c2", {axi.awvalid, axi.wvalid}, 2'b10);
    check_eq("t3_awaddr_held", axi.awaddr, 32'h1c0800f0);
    tick();
    axi.awready = 1; #1;
    check_eq("t3_aw_w_valid_c3", {axi.awvalid, axi.wvalid}, 2'b10);
    tick(); #1;
    check_eq("t3_aw_w_valid_c4", {axi.awvalid, axi.wvalid}, 2'b00);
    check_eq("t3_bready", axi.bready, 1);
    check_eq("t3_no_early_ok", data_sram.data_ok, 0);
    tick();
    axi.bvalid = 1; #1;
    check_eq("t3_data_ok", data_sram.data_ok, 1);
    tick();
    axi.bvalid = 0; #1;
    check_eq("t3_bready_drop", axi.bready, 0);

    // T4: slow B holds off a data read, inst read proceeds meanwhile
    data_sram.req = 1; data_sram.wr = 1; data_sram.addr = 32'h1c080010;
    data_sram.wdata = 32'h0badf00d; data_sram.wstrb = 4'hf; data_sram.size = 2;
    #1;
    check_eq("t4_wr_addr_ok", data_sram.addr_ok, 1);
    tick();
    data_sram.wr = 0; data_sram.addr = 32'h1c080020;
    inst_sram.req = 1; inst_sram.addr = 32'h1c000200; inst_sram.size = 2;
    #1;
    check_eq("t4_rd_held_c1", data_sram.addr_ok, 0);
    check_eq("t4_inst_addr_ok", inst_sram.addr_ok, 1);
    tick();
    inst_sram.req = 0; #1;
    check_eq("t4_inst_arid", axi.arid, 0);
    check_eq("t4_rd_held_c2", data_sram.addr_ok, 0);
    tick();
    drive_r(4'd0, 32'h55667788); #1;
    check_eq("t4_inst_data_ok", inst_sram.data_ok, 1);
    check_eq("t4_no_data_ok", data_sram.data_ok, 0);
    tick();
    axi.rvalid = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check_eq($sformatf("t4_rd_held_w%0d", i), data_sram.addr_ok, 0);
      tick();
    end
    axi.bvalid = 1; #1;
    check_eq("t4_wr_data_ok", data_sram.data_ok, 1);
    check_eq("t4_rd_held_bvalid", data_sram.addr_ok, 0);
    tick();
    axi.bvalid = 0; #1;
    check_eq("t4_rd_addr_ok", data_sram.addr_ok, 1);
    tick();
    data_sram.req = 0; #1;
    check_eq("t4_rd_arid", axi.arid, 1);
    check_eq("t4_rd_araddr", axi.araddr, 32'h1c080020);
    tick();
    drive_r(4'd1, 32'h99aabbcc); #1;
    check_eq("t4_rd_data_ok", data_sram.data_ok, 1);
    check_eq("t4_rd_rdata", data_sram.rdata, 32'h99aabbcc);
    tick();
    axi.rvalid = 0;

    // T5: concurrent inst read and data write, R and B in one cycle
    inst_sram.req = 1; inst_sram.addr = 32'h1c000300; inst_sram.size = 2;
    data_sram.req = 1; data_sram.wr = 1; data_sram.addr = 32'h1c080030;
    data_sram.wdata = 32'h12345678; data_sram.wstrb = 4'hf; data_sram.size = 2;
    #1;
    check_eq("t5_both_addr_ok", {inst_sram.addr_ok, data_sram.addr_ok}, 2'b11);
    tick();
    inst_sram.req = 0; data_sram.req = 0; data_sram.wr = 0; #1;
    check_eq("t5_valids", {axi.arvalid, axi.awvalid, axi.wvalid}, 3'b111);
    tick();
    drive_r(4'd0, 32'hcafef00d); axi.bvalid = 1; #1;
    check_eq("t5_both_data_ok", {inst_sram.data_ok, data_sram.data_ok}, 2'b11);
    check_eq("t5_inst_rdata", inst_sram.rdata, 32'hcafef00d);
    tick();
    axi.rvalid = 0; axi.bvalid = 0; #1;
    check_eq("t5_idle", {dbg_r_state, dbg_w_state}, 0);

    // T6: reset while waiting in R_R
    inst_sram.req = 1; inst_sram.addr = 32'h1c000400; inst_sram.size = 2;
    tick();
    inst_sram.req = 0;
    tick(); #1;
    check_eq("t6_rready_before", axi.rready, 1);
    reset = 1;
    tick();
    drive_r(4'd0, 32'hffffffff); #1;
    check_eq("t6_arvalid_rready", {axi.arvalid, axi.rready}, 2'b00);
    check_eq("t6_no_data_ok", inst_sram.data_ok, 0);
    reset = 0; axi.rvalid = 0;
    tick();
    inst_sram.req = 1; inst_sram.addr = 32'h1c000404; inst_sram.size = 0;
    exp_q.push_back(32'h0000005a);
    #1;
    check_eq("t6_fresh_addr_ok", inst_sram.addr_ok, 1);
    tick();
    inst_sram.req = 0; #1;
    check_eq("t6_fresh_araddr", axi.araddr, 32'h1c000404);
    check_eq("t6_fresh_arsize", axi.arsize, 0);
    tick();
    drive_r(4'd0, 32'h0000005a); #1;
    check_eq("t6_fresh_data_ok", inst_sram.data_ok, 1);
    pop_check("t6_fresh_rdata", inst_sram.rdata);
    tick();
    axi.rvalid = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
